// File: rtl/led_pattern_ctrl_if.sv
// Command channel for led_pattern_ctrl.
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : command can be accepted (slave -> master)
//   cmd_led    : target LED index
//   cmd_mode   : 0=OFF, 1=ON, 2=BLINK, 3=BURST
//   cmd_count  : burst on-pulse count (BURST only)
interface led_pattern_ctrl_if #(
  parameter int unsigned IDX_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_led;
  logic [1:0]       cmd_mode;
  logic [3:0]       cmd_count;

  modport master (
    output cmd_valid,
    output cmd_led,
    output cmd_mode,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_led,
    input  cmd_mode,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern controller driven by one shared prescaled tick.
// Each LED is OFF, ON, BLINK (toggle every tick) or BURST (N on-periods, then OFF).
//   clk        : system clock, posedge
//   rst        : asynchronous active-high reset
//   run        : 1 = prescaler counts, 0 = prescaler and LEDs frozen
//   cmd        : command channel (slave side of led_pattern_ctrl_if)
//   led        : LED drive, 1 = lit
//   burst_done : one-cycle pulse per LED when its burst completes
//   cmd_err    : one-cycle pulse for a command with an out-of-range index
module led_pattern_ctrl #(
  parameter int unsigned NUM_LED = 4,
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  led_pattern_ctrl_if.slave  cmd,
  output logic [NUM_LED-1:0] led,
  output logic [NUM_LED-1:0] burst_done,
  output logic               cmd_err
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ModeOff,
    ModeOn,
    ModeBlink,
    ModeBurst
  } mode_e;

  logic [DivW-1:0]  div_cnt;
  mode_e            mode_q [NUM_LED];
  logic [3:0]       rem_q  [NUM_LED];
  logic             tick;
  logic             accept;
  logic             idx_ok;
  logic [IDX_W-1:0] cmd_idx;

  assign cmd.cmd_ready = ~rst;
  assign cmd_idx       = cmd.cmd_led;
  assign tick          = run && (div_cnt == DivMax);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign idx_ok        = 32'(cmd_idx) < NUM_LED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      led        <= '0;
      burst_done <= '0;
      cmd_err    <= 1'b0;
      for (int i = 0; i < NUM_LED; i++) begin
        mode_q[i] <= ModeOff;
        rem_q[i]  <= 4'd0;
      end
    end else begin
      burst_done <= '0;
      cmd_err    <= accept && !idx_ok;

      if (run) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end

      for (int i = 0; i < NUM_LED; i++) begin
        // A command to this LED overrides any tick update in the same cycle.
        if (accept && (32'(cmd_idx) == 32'(i))) begin
          unique case (cmd.cmd_mode)
            2'd0: begin
              mode_q[i] <= ModeOff;
              led[i]    <= 1'b0;
            end
            2'd1: begin
              mode_q[i] <= ModeOn;
              led[i]    <= 1'b1;
            end
            2'd2: begin
              mode_q[i] <= ModeBlink;
              led[i]    <= 1'b1;
            end
            2'd3: begin
              if (cmd.cmd_count == 4'd0) begin
                mode_q[i]     <= ModeOff;
                led[i]        <= 1'b0;
                burst_done[i] <= 1'b1;
              end else begin
                mode_q[i] <= ModeBurst;
                led[i]    <= 1'b1;
                rem_q[i]  <= cmd.cmd_count;
              end
            end
            default: ;
          endcase
        end else if (tick) begin
          unique case (mode_q[i])
            ModeBlink: led[i] <= ~led[i];
            ModeBurst: begin
              if (led[i]) begin
                led[i]   <= 1'b0;
                rem_q[i] <= rem_q[i] - 4'd1;
                if (rem_q[i] == 4'd1) begin
                  mode_q[i]     <= ModeOff;
                  burst_done[i] <= 1'b1;
                end
              end else begin
                led[i] <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl (NUM_LED=4, CLK_DIV=4).
module tb_led_pattern_ctrl;

  localparam int NL = 4;
  localparam int CD = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [NL-1:0] led;
  logic [NL-1:0] burst_done;
  logic          cmd_err;

  led_pattern_ctrl_if #(.IDX_W(IW)) cmd_bus ();

  led_pattern_ctrl #(
    .NUM_LED(NL),
    .CLK_DIV(CD),
    .IDX_W  (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .cmd       (cmd_bus.slave),
    .led       (led),
    .burst_done(burst_done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0=off 1=on 2=blink 3=burst; m_pc = prescaler phase.
  int          m_mode [NL];
  bit          m_led  [NL];
  int          m_rem  [NL];
  bit [NL-1:0] m_done;
  bit          m_err;
  int          m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_mode[i] = 0;
      m_led[i]  = 1'b0;
      m_rem[i]  = 0;
    end
    m_done = '0;
    m_err  = 1'b0;
    m_pc   = 0;
  endtask

  // Called right after each posedge with the inputs the DUT just sampled.
  task automatic model_step();
    bit tk;
    int idx;
    int cnt;
    if (rst) begin
      model_reset();
      return;
    end
    tk     = run && (m_pc == CD - 1);
    if (run) m_pc = (m_pc + 1) % CD;
    m_done = '0;
    idx    = int'(cmd_bus.cmd_led);
    cnt    = int'(cmd_bus.cmd_count);
    m_err  = cmd_bus.cmd_valid && (idx >= NL);
    for (int i = 0; i < NL; i++) begin
      if (cmd_bus.cmd_valid && idx == i) begin
        case (int'(cmd_bus.cmd_mode))
          0: begin m_mode[i] = 0; m_led[i] = 1'b0; end
          1: begin m_mode[i] = 1; m_led[i] = 1'b1; end
          2: begin m_mode[i] = 2; m_led[i] = 1'b1; end
          default: begin
            if (cnt == 0) begin
              m_mode[i] = 0; m_led[i] = 1'b0; m_done[i] = 1'b1;
            end else begin
              m_mode[i] = 3; m_led[i] = 1'b1; m_rem[i] = cnt;
            end
          end
        endcase
      end else if (tk) begin
        if (m_mode[i] == 2) begin
          m_led[i] = !m_led[i];
        end else if (m_mode[i] == 3) begin
          if (m_led[i]) begin
            m_led[i] = 1'b0;
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) begin
              m_mode[i] = 0; m_done[i] = 1'b1;
            end
          end else begin
            m_led[i] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [NL-1:0] exp_led();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = m_led[i];
    return v;
  endfunction

  task automatic compare_all();
    check("led", 32'(led), 32'(exp_led()));
    check("burst_done", 32'(burst_done), 32'(m_done));
    check("cmd_err", 32'(cmd_err), 32'(m_err));
    check("cmd_ready", 32'(cmd_bus.cmd_ready), 32'(!rst));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input int idx, input int mode, input int count);
    cmd_bus.cmd_led   = IW'(idx);
    cmd_bus.cmd_mode  = 2'(mode);
    cmd_bus.cmd_count = 4'(count);
    cmd_bus.cmd_valid = 1'b1;
    step();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic align_tick();
    int g = 0;
    while (m_pc != CD - 1 && g < 10) begin
      step();
      g++;
    end
    check("align_bound", 32'(m_pc), 32'(CD - 1));
  endtask

  initial begin
    logic [NL-1:0] prev;
    int rises;
    int falls;
    int dones;
    int g;
    logic p;

    rst = 1'b1;
    run = 1'b1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_led   = '0;
    cmd_bus.cmd_mode  = '0;
    cmd_bus.cmd_count = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check("reset_led", 32'(led), 32'h0);
    rst = 1'b0;

    // Idle: nothing lights.
    repeat (40) step();
    check("idle_led", 32'(led), 32'h0);

    // BLINK LED0, freeze with run=0, then resume.
    send(0, 2, 0);
    check("blink_on", 32'(led), 32'h1);
    repeat (2) step();
    check("blink_hold", 32'(led[0]), 32'h1);
    step();
    check("blink_toggle", 32'(led[0]), 32'h0);
    run = 1'b0;
    repeat (10) step();
    check("frozen", 32'(led), 32'h0);
    run = 1'b1;
    repeat (3) step();
    check("resume_phase", 32'(led[0]), 32'h0);
    step();
    check("resume_toggle", 32'(led[0]), 32'h1);

    // BURST 3 on LED2.
    p = led[2];
    rises = 0;
    dones = 0;
    send(2, 3, 3);
    if (led[2] && !p) rises++;
    for (int c = 0; c < 40; c++) begin
      p = led[2];
      step();
      if (led[2] && !p) rises++;
      if (burst_done[2]) begin
        dones++;
        check("done_on_last_fall", 32'({p, led[2]}), 32'h2);
      end
    end
    check("burst3_rises", 32'(rises), 32'd3);
    check("burst3_dones", 32'(dones), 32'd1);
    check("burst3_end", 32'(led[2]), 32'h0);

    // BURST 0 on LED1, then invalid index.
    send(1, 3, 0);
    check("burst0_led", 32'(led[1]), 32'h0);
    check("burst0_done", 32'(burst_done), 32'h2);
    step();
    check("burst0_done_clr", 32'(burst_done), 32'h0);
    prev = led;
    send(5, 1, 0);
    check("bad_idx_err", 32'(cmd_err), 32'h1);
    check("bad_idx_led", 32'(led[3:1]), 32'(prev[3:1]));
    step();
    check("bad_idx_err_clr", 32'(cmd_err), 32'h0);

    // OFF to LED3 in its tick cycle; LED0 still toggles.
    send(3, 2, 0);
    align_tick();
    step();
    check("led3_after_tick", 32'(led[3]), 32'h0);
    align_tick();
    prev = led;
    send(3, 0, 0);
    check("off_wins", 32'(led[3]), 32'h0);
    check("other_toggles", 32'(led[0]), 32'(!prev[0]));

    // BURST 5 on LED1, async reset after two on-pulses.
    send(1, 3, 5);
    falls = 0;
    g = 0;
    while (falls < 2 && g < 100) begin
      p = led[1];
      step();
      if (p && !led[1]) falls++;
      g++;
    end
    check("burst5_two_pulses", 32'(falls), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_done", 32'(burst_done), 32'h0);
    model_reset();
    step();
    rst = 1'b0;
    rises = 0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      p = led[1];
      step();
      if (led[1] && !p) rises++;
      if (burst_done[1]) dones++;
    end
    check("post_rst_rises", 32'(rises), 32'd0);
    check("post_rst_dones", 32'(dones), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      run = ($urandom_range(0, 9) != 0);
      cmd_bus.cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_bus.cmd_led   = IW'($urandom_range(0, 5));
      cmd_bus.cmd_mode  = 2'($urandom_range(0, 3));
      cmd_bus.cmd_count = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
